divisor_punto_fijo: RTL and testbench

- Sequential saturating signed fixed-point divider, y = a / b.
- Uses the same 25-bit two's-complement format as the datapath multiplier: 1 sign bit, 8 integer bits, 16 fraction bits.
- Restoring division, one quotient bit per clock, with a start/done handshake.
- Sits beside the multiplier in the arithmetic unit. It has the same saturation semantics: clamp to 0x0FFFFFF / 0x1000000, never wrap.

---
 rtl/divisor_punto_fijo_pkg.sv | 21 ++
 rtl/saturador_punto_fijo.sv | 34 +++
 rtl/divisor_punto_fijo.sv | 163 ++++++++++++++++
 tb/tb_divisor_punto_fijo.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_punto_fijo_pkg.sv
// Shared fixed-point constants and state encoding for the divider and its
// companion multiplier in the arithmetic unit.
package divisor_punto_fijo_pkg;

  localparam int unsigned LARGO = 24;
  localparam int unsigned MAG   = 8;
  localparam int unsigned PRES  = 16;
  localparam int unsigned ITER  = LARGO + PRES + 1;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [LARGO:0] MAX_POS = {1'b0, {LARGO{1'b1}}};
  localparam logic [LARGO:0] MIN_NEG = {1'b1, {LARGO{1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCalc,
    StSat
  } state_e;

endpackage

// File: rtl/saturador_punto_fijo.sv
// Clamps an unsigned wide quotient plus sign into the signed fixed-point word,
// never wrapping; shared with the multiplier.
module saturador_punto_fijo #(
  parameter int unsigned largo = 24,
  parameter int unsigned qw    = 41
) (
  input  logic              sign_i,
  input  logic [qw-1:0]     quo_i,
  input  logic              div0_i,
  output logic [largo:0]    y_o,
  output logic              ovf_o
);

  localparam logic [qw-1:0]  PosLim = {{(qw - largo){1'b0}}, {largo{1'b1}}};
  localparam logic [qw-1:0]  NegLim = {{(qw - largo - 1){1'b0}}, 1'b1, {largo{1'b0}}};
  localparam logic [largo:0] MaxPos = {1'b0, {largo{1'b1}}};
  localparam logic [largo:0] MinNeg = {1'b1, {largo{1'b0}}};

  logic [largo:0] mag;
  assign mag = quo_i[largo:0];

  always_comb begin
    y_o   = mag;
    ovf_o = 1'b0;
    if (div0_i || (!sign_i && (quo_i > PosLim)) || (sign_i && (quo_i > NegLim))) begin
      ovf_o = 1'b1;
      y_o   = sign_i ? MinNeg : MaxPos;
    end else if (sign_i) begin
      // -0 folds back to 0 naturally in two's complement
      y_o = ~mag + 1'b1;
    end
  end

endmodule

// File: rtl/divisor_punto_fijo.sv
// Sequential saturating signed fixed-point divider (restoring, one quotient
// bit per clock) with start/done handshake.
module divisor_punto_fijo
  import divisor_punto_fijo_pkg::*;
#(
  parameter int unsigned largo = LARGO,
  parameter int unsigned mag   = MAG,
  parameter int unsigned pres  = PRES
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [largo:0] a,
  input  logic [largo:0] b,
  output logic [largo:0] y,
  output logic           done,
  output logic           busy,
  output logic           ovf,
  output logic           div0
);

  localparam int unsigned Iter = largo + pres + 1;
  localparam int unsigned CntW = $clog2(Iter);

  if (largo != mag + pres) begin : gen_cfg_err
    $error("divisor_punto_fijo: largo must equal mag + pres");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [largo:0]    opa_q, opa_d, opb_q, opb_d;
  logic [largo:0]    mag_b_q, mag_b_d;
  logic [Iter-1:0]   dvd_q, dvd_d, quo_q, quo_d;
  logic [largo+1:0]  rem_q, rem_d;
  logic              sign_q, sign_d, a_zero_q, a_zero_d, b_zero_q, b_zero_d;
  logic [largo:0]    y_q, y_d;
  logic              ovf_q, ovf_d, div0_q, div0_d, done_q, done_d;

  logic [largo:0]    mag_a, mag_b;
  logic [largo+1:0]  rem_sh, rem_nx;
  logic              ge;
  logic [largo:0]    sat_y;
  logic              sat_ovf;

  // Magnitudes fit in largo+1 unsigned bits, so |-2^largo| is exact
  assign mag_a  = opa_q[largo] ? (~opa_q + 1'b1) : opa_q;
  assign mag_b  = opb_q[largo] ? (~opb_q + 1'b1) : opb_q;
  assign rem_sh = {rem_q[largo:0], dvd_q[Iter-1]};
  assign ge     = rem_sh >= {1'b0, mag_b_q};
  assign rem_nx = ge ? (rem_sh - {1'b0, mag_b_q}) : rem_sh;

  saturador_punto_fijo #(
    .largo (largo),
    .qw    (Iter)
  ) u_sat (
    .sign_i (sign_q),
    .quo_i  (a_zero_q ? '0 : quo_q),
    .div0_i (b_zero_q & ~a_zero_q),
    .y_o    (sat_y),
    .ovf_o  (sat_ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mag_b_d  = mag_b_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    sign_d   = sign_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          state_d = StLoad;
        end
      end
      StLoad: begin
        sign_d   = opa_q[largo] ^ opb_q[largo];
        a_zero_d = (opa_q == '0);
        b_zero_d = (opb_q == '0);
        mag_b_d  = mag_b;
        dvd_d    = {mag_a, {pres{1'b0}}};
        rem_d    = '0;
        quo_d    = '0;
        cnt_d    = '0;
        state_d  = StCalc;
      end
      StCalc: begin
        rem_d = rem_nx;
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[Iter-2:0], ge};
        if (cnt_q == CntW'(Iter - 1)) begin
          cnt_d   = '0;
          state_d = StSat;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSat: begin
        y_d     = sat_y;
        ovf_d   = sat_ovf;
        div0_d  = b_zero_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      mag_b_q  <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mag_b_q  <= mag_b_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      sign_q   <= sign_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign y    = y_q;
  assign ovf  = ovf_q;
  assign div0 = div0_q;
  assign done = done_q;
  // done lands back in IDLE, so it is folded in to keep busy high that cycle
  assign busy = (state_q != StIdle) | done_q;

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// Self-checking bench for divisor_punto_fijo: scoreboard of expected results
// built from an integer-division reference model plus fixed vectors.
module tb_divisor_punto_fijo;

  typedef struct packed {
    logic [24:0] y;
    logic        ovf;
    logic        div0;
  } exp_t;

  typedef struct packed {
    logic [24:0] a;
    logic [24:0] b;
    logic [24:0] y;
    logic        ovf;
    logic        div0;
  } vec_t;

  localparam int Lat = 43;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [24:0] a = '0;
  logic [24:0] b = '0;
  logic [24:0] y;
  logic        done, busy, ovf, div0;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  divisor_punto_fijo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .y       (y),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [24:0] x, input logic [24:0] d);
    exp_t            e;
    longint unsigned mx, md, q;
    logic            s;
    s  = x[24] ^ d[24];
    mx = 64'(x);
    md = 64'(d);
    if (x[24]) mx = 64'd33554432 - mx;
    if (d[24]) md = 64'd33554432 - md;
    e.div0 = (d == 25'd0);
    e.ovf  = 1'b0;
    e.y    = '0;
    if (d == 25'd0) begin
      if (x != 25'd0) begin
        e.ovf = 1'b1;
        e.y   = x[24] ? 25'h1000000 : 25'h0FFFFFF;
      end
    end else begin
      q = (mx << 16) / md;
      if (!s && q > 64'hFFFFFF) begin
        e.ovf = 1'b1;
        e.y   = 25'h0FFFFFF;
      end else if (s && q > 64'h1000000) begin
        e.ovf = 1'b1;
        e.y   = 25'h1000000;
      end else begin
        e.y = s ? 25'(64'd33554432 - q) : 25'(q);
      end
    end
    return e;
  endfunction

  // Leaves the caller #1 after the edge that sampled start
  task automatic start_op(input logic [24:0] x, input logic [24:0] d);
    @(posedge clk);
    #1;
    a     = x;
    b     = d;
    start = 1'b1;
    sb.push_back(model(x, d));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output bit to);
    n  = n0;
    to = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= 100) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({y, ovf, div0, done, busy} !== 29'd0) begin
      bad++;
      $display("FAIL reset_asserted: got y=%h ovf=%b div0=%b done=%b busy=%b want all 0",
               y, ovf, div0, done, busy);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({y, ovf, div0, done, busy} !== 29'd0) begin
      bad++;
      $display("FAIL reset_released: got y=%h ovf=%b div0=%b done=%b busy=%b want all 0",
               y, ovf, div0, done, busy);
    end
  endtask

  task automatic test_basic();
    int   n;
    bit   to;
    exp_t e;
    start_op(25'h060000, 25'h020000);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    wait_done(0, n, to);
    total++;
    if (to || n != Lat) begin
      bad++;
      $display("FAIL basic_latency: got %0d (timeout=%0b) want %0d", n, to, Lat);
    end
    e = sb.pop_front();
    total++;
    if ({y, ovf, div0} !== {e.y, e.ovf, e.div0} || y !== 25'h030000) begin
      bad++;
      $display("FAIL basic_6_div_2: got y=%h ovf=%b div0=%b want y=030000 ovf=0 div0=0",
               y, ovf, div0);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_done_cycle: got %b want 1", busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || y !== 25'h030000) begin
      bad++;
      $display("FAIL after_done: got done=%b busy=%b y=%h want done=0 busy=0 y=030000",
               done, busy, y);
    end
  endtask

  task automatic test_vectors();
    vec_t tbl [0:12] = '{
      '{25'h060000,  25'h020000,  25'h030000,  1'b0, 1'b0},
      '{25'h1FF0000, 25'h040000,  25'h1FFC000, 1'b0, 1'b0},
      '{25'h010000,  25'h030000,  25'h005555,  1'b0, 1'b0},
      '{25'h640000,  25'h004000,  25'h0FFFFFF, 1'b1, 1'b0},
      '{25'h19C0000, 25'h004000,  25'h1000000, 1'b1, 1'b0},
      '{25'h1000000, 25'h010000,  25'h1000000, 1'b0, 1'b0},
      '{25'h1000000, 25'h1FF0000, 25'h0FFFFFF, 1'b1, 1'b0},
      '{25'h0FFFFFF, 25'h010000,  25'h0FFFFFF, 1'b0, 1'b0},
      '{25'h1FF0000, 25'h1FC0000, 25'h004000,  1'b0, 1'b0},
      '{25'h050000,  25'h000000,  25'h0FFFFFF, 1'b1, 1'b1},
      '{25'h000000,  25'h000000,  25'h000000,  1'b0, 1'b1},
      '{25'h1FB0000, 25'h000000,  25'h1000000, 1'b1, 1'b1},
      '{25'h000000,  25'h1FC0000, 25'h000000,  1'b0, 1'b0}
    };
    int   n;
    bit   to;
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      start_op(tbl[i].a, tbl[i].b);
      wait_done(0, n, to);
      total++;
      if (to || n != Lat) begin
        bad++;
        $display("FAIL vec%0d_latency: got %0d (timeout=%0b) want %0d", i, n, to, Lat);
      end
      e = sb.pop_front();
      total++;
      if ({y, ovf, div0} !== {tbl[i].y, tbl[i].ovf, tbl[i].div0} ||
          {y, ovf, div0} !== {e.y, e.ovf, e.div0}) begin
        bad++;
        $display("FAIL vec%0d a=%h b=%h: got y=%h ovf=%b div0=%b want y=%h ovf=%b div0=%b",
                 i, tbl[i].a, tbl[i].b, y, ovf, div0, tbl[i].y, tbl[i].ovf, tbl[i].div0);
      end
    end
  endtask

  task automatic test_random();
    int          n;
    bit          to;
    exp_t        e;
    logic [24:0] x, d;
    for (int i = 0; i < 10; i++) begin
      x = 25'($urandom);
      d = (i % 2 == 0) ? 25'($urandom) : 25'($urandom_range(1, 32'h3FFFF));
      if (i % 3 == 0) d = ~d + 25'd1;
      start_op(x, d);
      wait_done(0, n, to);
      e = sb.pop_front();
      total++;
      if (to || {y, ovf, div0} !== {e.y, e.ovf, e.div0}) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h: got y=%h ovf=%b div0=%b want y=%h ovf=%b div0=%b",
                 i, x, d, y, ovf, div0, e.y, e.ovf, e.div0);
      end
    end
  endtask

  task automatic test_ignored_start();
    int   n, extra;
    bit   to;
    exp_t e;
    start_op(25'h060000, 25'h020000);
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      n++;
    end
    a     = 25'h640000;
    b     = 25'h004000;
    start = 1'b1;
    @(posedge clk);
    #1;
    n++;
    start = 1'b0;
    wait_done(n, n, to);
    total++;
    if (to || n != Lat) begin
      bad++;
      $display("FAIL ignored_latency: got %0d (timeout=%0b) want %0d", n, to, Lat);
    end
    e = sb.pop_front();
    total++;
    if ({y, ovf, div0} !== {e.y, e.ovf, e.div0}) begin
      bad++;
      $display("FAIL ignored_result: got y=%h ovf=%b div0=%b want y=%h ovf=%b div0=%b",
               y, ovf, div0, e.y, e.ovf, e.div0);
    end
    extra = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignored_single_done: got %0d extra done pulses want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int   n, extra;
    bit   to;
    exp_t e;
    start_op(25'h010000, 25'h030000);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({y, ovf, div0, done, busy} !== 29'd0) begin
      bad++;
      $display("FAIL abort_reset_state: got y=%h ovf=%b div0=%b done=%b busy=%b want all 0",
               y, ovf, div0, done, busy);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    extra = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    total++;
    if (extra != 0 || y !== 25'd0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses y=%h want 0 pulses y=0", extra, y);
    end
    start_op(25'h060000, 25'h020000);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++;
    if (to || n != Lat || {y, ovf, div0} !== {e.y, e.ovf, e.div0}) begin
      bad++;
      $display("FAIL abort_restart: got n=%0d y=%h ovf=%b div0=%b want n=%0d y=%h",
               n, y, ovf, div0, Lat, e.y);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    bit   to;
    exp_t e;
    start_op(25'h1FF0000, 25'h040000);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++;
    if (to || {y, ovf, div0} !== {e.y, e.ovf, e.div0}) begin
      bad++;
      $display("FAIL b2b_first: got y=%h ovf=%b div0=%b want y=%h", y, ovf, div0, e.y);
    end
    start_op(25'h19C0000, 25'h004000);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++;
    if (to || n != Lat || {y, ovf, div0} !== {e.y, e.ovf, e.div0}) begin
      bad++;
      $display("FAIL b2b_second: got n=%0d y=%h ovf=%b div0=%b want n=%0d y=%h ovf=%b",
               n, y, ovf, div0, Lat, e.y, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_random();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
